// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing types and constants for eth_frame_serializer.
// ETH_TX_PAD_EN adds the PAD state to the serializer state encoding.
package eth_pkg;

    localparam int ETH_HDR_LEN = 14;
    localparam int ETH_MIN_FRAME_LEN = 60;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;

`ifdef ETH_TX_PAD_EN
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PAD} eth_tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} eth_tx_state_t;
`endif

    // Byte i of {dest, src, type}, wire order (MSB first).
    function automatic logic [7:0] hdr_byte(input logic [111:0] h, input logic [3:0] i);
        logic [111:0] s;
        s = h << {i, 3'b000};
        return s[111:104];
    endfunction

endpackage

// File: rtl/eth_frame_serializer.sv
// eth_frame_serializer: serializes an Ethernet header plus payload stream into one byte stream.
// Define ETH_TX_PAD_EN to zero-pad frames shorter than MIN_FRAME_LEN bytes (FCS excluded).
module eth_frame_serializer
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = ETH_MIN_FRAME_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_eth_payload_axis_tdata,
    input  logic        s_eth_payload_axis_tvalid,
    output logic        s_eth_payload_axis_tready,
    input  logic        s_eth_payload_axis_tlast,
    input  logic        s_eth_payload_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        busy
);

    localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);

    eth_tx_state_t state;
    logic [111:0]  hdr;
    logic [3:0]    hdr_idx;
    logic [10:0]   count;
    logic [10:0]   count_inc;
    logic          adv;

    assign adv = !m_axis_tvalid || m_axis_tready;
    assign count_inc = (count == 11'h7ff) ? count : count + 11'd1;
    // Gated by rst_n so the handshake is withheld for the whole reset pulse.
    assign s_eth_hdr_ready = rst_n && state == IDLE && adv;
    assign s_eth_payload_axis_tready = state == PAYLOAD && adv;
    assign busy = state != IDLE;

`ifdef ETH_TX_PAD_EN
    logic frame_full;
    assign frame_full = {1'b0, count_inc} >= 12'(MIN_FRAME_LEN);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hdr <= '0;
            hdr_idx <= '0;
            count <= '0;
            m_axis_tdata <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else if (adv) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
            case (state)
                IDLE: if (s_eth_hdr_valid) begin
                    hdr <= {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
                    m_axis_tdata <= s_eth_dest_mac[47:40];
                    m_axis_tvalid <= 1'b1;
                    hdr_idx <= 4'd1;
                    count <= 11'd1;
                    state <= HEADER;
                end
                HEADER: begin
                    m_axis_tdata <= hdr_byte(hdr, hdr_idx);
                    m_axis_tvalid <= 1'b1;
                    hdr_idx <= hdr_idx + 4'd1;
                    count <= count_inc;
                    if (hdr_idx == HDR_LAST) state <= PAYLOAD;
                end
                PAYLOAD: if (s_eth_payload_axis_tvalid) begin
                    m_axis_tdata <= s_eth_payload_axis_tdata;
                    m_axis_tvalid <= 1'b1;
                    count <= count_inc;
`ifdef ETH_TX_PAD_EN
                    if (s_eth_payload_axis_tlast && !s_eth_payload_axis_tuser && !frame_full) begin
                        state <= PAD;
                    end else begin
                        m_axis_tlast <= s_eth_payload_axis_tlast;
                        m_axis_tuser <= s_eth_payload_axis_tuser;
                        if (s_eth_payload_axis_tlast) state <= IDLE;
                    end
`else
                    m_axis_tlast <= s_eth_payload_axis_tlast;
                    m_axis_tuser <= s_eth_payload_axis_tuser;
                    if (s_eth_payload_axis_tlast) state <= IDLE;
`endif
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    m_axis_tdata <= 8'h00;
                    m_axis_tvalid <= 1'b1;
                    count <= count_inc;
                    if (frame_full) begin
                        m_axis_tlast <= 1'b1;
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_serializer.sv
// tb_eth_frame_serializer: randomized self-checking bench against a queue-based frame model.
// Expectations follow ETH_TX_PAD_EN when it is defined for the build.
module tb_eth_frame_serializer;
    import eth_pkg::*;

    localparam int MIN = 60;
`ifdef ETH_TX_PAD_EN
    localparam int PAD_LEN = 60;
`else
    localparam int PAD_LEN = 24;
`endif

    typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
    typedef logic [7:0] bq_t[$];

    logic        clk, rst_n;
    logic        s_eth_hdr_valid, s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac, s_eth_src_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  s_eth_payload_axis_tdata;
    logic        s_eth_payload_axis_tvalid, s_eth_payload_axis_tready;
    logic        s_eth_payload_axis_tlast, s_eth_payload_axis_tuser;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, busy;

    eth_frame_serializer #(.MIN_FRAME_LEN(MIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .busy(busy)
    );

    int n_cmp = 0, n_err = 0;
    int ready_mode = 0;
    int stall_viol = 0, hb_viol = 0;
    bit abort = 0;
    beat_t got_q[$];
    bq_t bc_pay;
    beat_t bc_exp[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sink: 0 = always ready, 1 = toggle, 2 = random
    initial begin
        m_axis_tready = 1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? !m_axis_tready : ($urandom_range(2) != 0);
        end
    end

    // Monitor at negedge: inputs and registered outputs are settled until the next posedge
    initial begin
        logic p_stall;
        logic [9:0] p_beat;
        p_stall = 0;
        p_beat = '0;
        forever begin
            @(negedge clk);
            if (rst_n && m_axis_tvalid && m_axis_tready) got_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser});
            if (rst_n && p_stall && (!m_axis_tvalid || {m_axis_tdata, m_axis_tlast, m_axis_tuser} !== p_beat)) stall_viol++;
            if (s_eth_hdr_ready && (busy || (m_axis_tvalid && !m_axis_tready))) hb_viol++;
            p_stall = rst_n && m_axis_tvalid && !m_axis_tready;
            p_beat = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    function automatic void model(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                                  input bq_t p, input bit user, output beat_t q[$]);
        logic [111:0] h;
        h = {d, s, t};
        q.delete();
        for (int i = 0; i < 14; i++) q.push_back('{h[111 - 8*i -: 8], 1'b0, 1'b0});
        foreach (p[i]) q.push_back('{p[i], i == p.size() - 1, user && i == p.size() - 1});
`ifdef ETH_TX_PAD_EN
        if (!user && q.size() < MIN) begin
            q[q.size() - 1].l = 1'b0;
            while (q.size() < MIN) q.push_back('{8'h00, 1'b0, 1'b0});
            q[MIN - 1].l = 1'b1;
        end
`endif
    endfunction

    function automatic int ndiff(input beat_t a[$], input beat_t b[$]);
        int n;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    function automatic bq_t rand_pay(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            output bit ok, output int lasts);
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 1;
        s_eth_dest_mac = d;
        s_eth_src_mac = s;
        s_eth_type = t;
        ok = 0;
        lasts = 0;
        for (int k = 0; k < 3000 && !ok && !abort; k++) begin
            @(negedge clk);
            if (s_eth_hdr_ready) begin
                ok = 1;
                lasts = (m_axis_tvalid && m_axis_tlast) ? 1 : 0;
                foreach (got_q[i]) if (got_q[i].l) lasts++;
            end
        end
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 0;
    endtask

    task automatic send_pay(input bq_t p, input bit user, input bit gaps, output bit ok);
        ok = 1;
        for (int i = 0; i < p.size() && ok; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                s_eth_payload_axis_tvalid = 0;
                @(posedge clk);
                #1;
            end
            s_eth_payload_axis_tdata = p[i];
            s_eth_payload_axis_tvalid = 1;
            s_eth_payload_axis_tlast = (i == p.size() - 1);
            s_eth_payload_axis_tuser = s_eth_payload_axis_tlast && user;
            ok = 0;
            for (int k = 0; k < 3000 && !ok && !abort; k++) begin
                @(negedge clk);
                if (s_eth_payload_axis_tready) ok = 1;
            end
            @(posedge clk);
            #1;
        end
        s_eth_payload_axis_tvalid = 0;
        s_eth_payload_axis_tlast = 0;
        s_eth_payload_axis_tuser = 0;
    endtask

    task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input bq_t p, input bit user, input bit gaps, output bit ok);
        bit o1, o2;
        int l;
        fork
            send_hdr(d, s, t, o1, l);
            send_pay(p, user, gaps, o2);
        join
        ok = o1 && o2;
    endtask

    task automatic wait_frame(input int n);
        for (int k = 0; k < 5000 && got_q.size() < n; k++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, s_eth_hdr_ready, s_eth_payload_axis_tready, busy} !== 14'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, s_eth_hdr_ready, s_eth_payload_axis_tready, busy});
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({s_eth_hdr_ready, m_axis_tvalid, busy} !== 3'b100) begin
            n_err++;
            $display("FAIL post_reset_idle: got hdr_ready/tvalid/busy=%b want 100", {s_eth_hdr_ready, m_axis_tvalid, busy});
        end
    endtask

    task automatic test_broadcast();
        bit o1, o2, lat_ok;
        int l;
        ready_mode = 0;
        got_q.delete();
        bc_pay = rand_pay(46);
        model(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, ETH_TYPE_ARP, bc_pay, 0, bc_exp);
        fork
            begin
                send_hdr(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, ETH_TYPE_ARP, o1, l);
                @(negedge clk);
                lat_ok = m_axis_tvalid === 1'b1 && m_axis_tdata === 8'hFF;
            end
            send_pay(bc_pay, 0, 0, o2);
        join
        wait_frame(bc_exp.size());
        n_cmp++;
        if ({o1, o2} !== 2'b11) begin
            n_err++;
            $display("FAIL bcast_handshake: got hdr/pay ok=%b want 11", {o1, o2});
        end
        n_cmp++;
        if (lat_ok !== 1'b1) begin
            n_err++;
            $display("FAIL bcast_latency: got first byte present=%b want 1", lat_ok);
        end
        n_cmp++;
        if (got_q.size() !== 60) begin
            n_err++;
            $display("FAIL bcast_len: got %0d want 60", got_q.size());
        end
        n_cmp++;
        if (ndiff(got_q, bc_exp) !== 0) begin
            n_err++;
            $display("FAIL bcast_bytes: got %0d differing beats want 0", ndiff(got_q, bc_exp));
        end
        n_cmp++;
        if ({m_axis_tvalid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL bcast_idle: got tvalid/busy=%b want 00", {m_axis_tvalid, busy});
        end
    endtask

    task automatic test_stall();
        bit ok;
        beat_t e[$];
        bq_t p;
        logic [47:0] d, s;
        ready_mode = 1;
        got_q.delete();
        stall_viol = 0;
        d = 48'({$urandom, $urandom});
        s = 48'({$urandom, $urandom});
        p = rand_pay(100);
        model(d, s, ETH_TYPE_IPV4, p, 0, e);
        run_frame(d, s, ETH_TYPE_IPV4, p, 0, 0, ok);
        wait_frame(e.size());
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL stall_handshake: got %b want 1", ok);
        end
        n_cmp++;
        if (got_q.size() !== 114) begin
            n_err++;
            $display("FAIL stall_len: got %0d want 114", got_q.size());
        end
        n_cmp++;
        if (stall_viol !== 0) begin
            n_err++;
            $display("FAIL stall_hold: got %0d changes while stalled want 0", stall_viol);
        end
        n_cmp++;
        if (ndiff(got_q, e) !== 0) begin
            n_err++;
            $display("FAIL stall_bytes: got %0d differing beats want 0", ndiff(got_q, e));
        end
    endtask

    task automatic test_pad();
        bit ok;
        beat_t e[$];
        bq_t p;
        ready_mode = 0;
        got_q.delete();
        p = rand_pay(10);
        model(48'h0011_2233_4455, 48'h0200_0000_0002, ETH_TYPE_IPV4, p, 0, e);
        run_frame(48'h0011_2233_4455, 48'h0200_0000_0002, ETH_TYPE_IPV4, p, 0, 0, ok);
        wait_frame(e.size());
        n_cmp++;
        if (got_q.size() !== PAD_LEN) begin
            n_err++;
            $display("FAIL pad_len: got %0d want %0d", got_q.size(), PAD_LEN);
        end
        n_cmp++;
        if (got_q.size() < PAD_LEN || got_q[PAD_LEN - 1].l !== 1'b1 || got_q[PAD_LEN - 1].u !== 1'b0) begin
            n_err++;
            $display("FAIL pad_last: got size %0d, final beat not tlast=1 tuser=0 at byte %0d", got_q.size(), PAD_LEN);
        end
        n_cmp++;
        if (ndiff(got_q, e) !== 0) begin
            n_err++;
            $display("FAIL pad_bytes: got %0d differing beats want 0", ndiff(got_q, e));
        end
    endtask

    task automatic test_user();
        bit ok;
        beat_t e[$];
        bq_t p;
        ready_mode = 2;
        got_q.delete();
        p = rand_pay(5);
        model(48'h0A0B_0C0D_0E0F, 48'h0200_0000_0003, ETH_TYPE_ARP, p, 1, e);
        run_frame(48'h0A0B_0C0D_0E0F, 48'h0200_0000_0003, ETH_TYPE_ARP, p, 1, 1, ok);
        wait_frame(e.size());
        n_cmp++;
        if (got_q.size() !== 19) begin
            n_err++;
            $display("FAIL user_len: got %0d want 19", got_q.size());
        end
        n_cmp++;
        if (got_q.size() < 19 || {got_q[18].l, got_q[18].u} !== 2'b11) begin
            n_err++;
            $display("FAIL user_flags: byte 19 tlast/tuser not 11 (size %0d)", got_q.size());
        end
        n_cmp++;
        if (ndiff(got_q, e) !== 0) begin
            n_err++;
            $display("FAIL user_bytes: got %0d differing beats want 0", ndiff(got_q, e));
        end
    endtask

    task automatic test_back_to_back();
        bit oa, ob, pa_ok, pb_ok;
        int la, lb;
        beat_t ea[$], eb[$];
        bq_t pa, pb;
        ready_mode = 2;
        got_q.delete();
        hb_viol = 0;
        pa = rand_pay(20);
        pb = rand_pay($urandom_range(1, 70));
        model(48'h1111_2222_3333, 48'h0200_0000_0004, ETH_TYPE_IPV4, pa, 0, ea);
        model(48'h4444_5555_6666, 48'h0200_0000_0005, ETH_TYPE_ARP, pb, 0, eb);
        foreach (eb[i]) ea.push_back(eb[i]);
        fork
            begin
                send_hdr(48'h1111_2222_3333, 48'h0200_0000_0004, ETH_TYPE_IPV4, oa, la);
                send_hdr(48'h4444_5555_6666, 48'h0200_0000_0005, ETH_TYPE_ARP, ob, lb);
            end
            begin
                send_pay(pa, 0, 0, pa_ok);
                send_pay(pb, 0, 0, pb_ok);
            end
        join
        wait_frame(ea.size());
        n_cmp++;
        if ({oa, ob, pa_ok, pb_ok} !== 4'b1111) begin
            n_err++;
            $display("FAIL b2b_handshake: got %b want 1111", {oa, ob, pa_ok, pb_ok});
        end
        n_cmp++;
        if (lb < 1 || la !== 0) begin
            n_err++;
            $display("FAIL b2b_hdr_order: got tlasts before hdr1=%0d hdr2=%0d want 0 and >=1", la, lb);
        end
        n_cmp++;
        if (hb_viol !== 0) begin
            n_err++;
            $display("FAIL b2b_hdr_ready: got %0d ready-while-busy cycles want 0", hb_viol);
        end
        n_cmp++;
        if (ndiff(got_q, ea) !== 0) begin
            n_err++;
            $display("FAIL b2b_bytes: got %0d differing beats want 0 (size %0d vs %0d)", ndiff(got_q, ea), got_q.size(), ea.size());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            bit ok, user;
            beat_t e[$];
            bq_t p;
            logic [47:0] d, s;
            logic [15:0] t;
            ready_mode = $urandom_range(2);
            got_q.delete();
            d = 48'({$urandom, $urandom});
            s = 48'({$urandom, $urandom});
            t = $urandom_range(1) ? ETH_TYPE_IPV4 : ETH_TYPE_ARP;
            user = $urandom_range(3) == 0;
            p = rand_pay($urandom_range(1, 80));
            model(d, s, t, p, user, e);
            run_frame(d, s, t, p, user, 1, ok);
            wait_frame(e.size());
            n_cmp++;
            if (!ok || ndiff(got_q, e) !== 0) begin
                n_err++;
                $display("FAIL random_frame%0d: got ok=%b, %0d differing beats want 0 (len %0d)", f, ok, ndiff(got_q, e), p.size());
            end
        end
    endtask

    task automatic test_mid_reset();
        bit o1, o2, ok;
        int l, lasts;
        logic [13:0] rv;
        ready_mode = 0;
        got_q.delete();
        lasts = 0;
        rv = '1;
        fork
            send_hdr(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, ETH_TYPE_ARP, o1, l);
            send_pay(bc_pay, 0, 0, o2);
            begin
                for (int k = 0; k < 3000 && got_q.size() < 34; k++) @(negedge clk);
                #2;
                rst_n = 0;
                abort = 1;
                #1;
                rv = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, s_eth_hdr_ready, s_eth_payload_axis_tready, busy};
                foreach (got_q[i]) if (got_q[i].l) lasts++;
            end
        join
        n_cmp++;
        if (rv !== 14'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %b want 0", rv);
        end
        n_cmp++;
        if (lasts !== 0 || got_q.size() < 34 || got_q.size() >= 60) begin
            n_err++;
            $display("FAIL midreset_truncate: got %0d beats with %0d tlast want 34..59 beats and 0 tlast", got_q.size(), lasts);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        abort = 0;
        got_q.delete();
        run_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, ETH_TYPE_ARP, bc_pay, 0, 0, ok);
        wait_frame(bc_exp.size());
        n_cmp++;
        if (!ok || ndiff(got_q, bc_exp) !== 0) begin
            n_err++;
            $display("FAIL midreset_next_frame: got ok=%b, %0d differing beats want 0", ok, ndiff(got_q, bc_exp));
        end
    endtask

    initial begin
        rst_n = 0;
        s_eth_hdr_valid = 0;
        s_eth_dest_mac = '0;
        s_eth_src_mac = '0;
        s_eth_type = '0;
        s_eth_payload_axis_tdata = '0;
        s_eth_payload_axis_tvalid = 0;
        s_eth_payload_axis_tlast = 0;
        s_eth_payload_axis_tuser = 0;
        test_reset();
        test_broadcast();
        test_stall();
        test_pad();
        test_user();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
